// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM states and
// configuration limits.
package bus_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int BUS_MAX_MASTERS  = 8;
    localparam int BUS_DEF_MAX_HOLD = 16;
endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
interface bus_rr_arbiter_if #(
    parameter int N_MASTER = 4
);
    localparam int IW = $clog2(N_MASTER);

    logic [N_MASTER-1:0] req;
    logic [N_MASTER-1:0] grant;
    logic [IW-1:0]       grant_id;
    logic                grant_valid;
    logic                timeout_evt;

    modport master (output req, input grant, grant_id, grant_valid, timeout_evt);
    modport slave  (input req, output grant, grant_id, grant_valid, timeout_evt);
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    localparam logic [IW:0] N_W = N[IW:0];

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    assign any_o = |req_i;

    always_comb begin
        // Rotate so bit 0 is the master at ptr; lowest set bit is the winner offset.
        rot = N'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= N_W) sum = sum - N_W;
        idx_o = sum[IW-1:0];
        win_o = any_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with a mandatory dead cycle between owners.
// Optional forced rotation after MAX_HOLD cycles when HOLD_TIMEOUT_EN is defined.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int MAX_HOLD = BUS_DEF_MAX_HOLD
) (
    input logic            clk,
    input logic            reset_n,
    bus_rr_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_MASTER);

    generate
        if (N_MASTER < 2 || N_MASTER > BUS_MAX_MASTERS || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
            $error("bus_rr_arbiter: N_MASTER or MAX_HOLD out of range");
        end
    endgenerate

    arb_state_e          state_q;
    logic [N_MASTER-1:0] grant_q;
    logic [IW-1:0]       grant_id_q;
    logic                grant_valid_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       nxt_ptr_d;
    logic                owner_req;

    logic [N_MASTER-1:0] pick_win;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;

    rr_pick #(.N(N_MASTER)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // On any release the owner drops to lowest priority.
    assign nxt_ptr_d = (grant_id_q == IW'(N_MASTER - 1)) ? '0 : grant_id_q + IW'(1);
    assign owner_req = bus.req[grant_id_q];

`ifdef HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    logic [7:0] hold_q;
    logic       timeout_q;
    logic       others_req;
    assign others_req = |(bus.req & ~grant_q);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= '0;
`ifdef HOLD_TIMEOUT_EN
            hold_q        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef HOLD_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q       <= GRANT;
                        grant_q       <= pick_win;
                        grant_id_q    <= pick_idx;
                        grant_valid_q <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
                        hold_q        <= 8'd1;
`endif
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= nxt_ptr_d;
`ifdef HOLD_TIMEOUT_EN
                    end else if (hold_q == HOLD_MAX && others_req) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= nxt_ptr_d;
                        timeout_q     <= 1'b1;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q        <= hold_q + 8'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
`ifdef HOLD_TIMEOUT_EN
    assign bus.timeout_evt = timeout_q;
`else
    assign bus.timeout_evt = 1'b0;
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_bus_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;
`ifdef HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    bus_rr_arbiter_if #(.N_MASTER(N)) bif ();

    bus_rr_arbiter #(.N_MASTER(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    // Behavioural model: owner (-1 = bus free), rotation start, hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_last  = 0;
    bit m_tevt  = 1'b0;

    always @(posedge clk) begin
        logic [N-1:0] r;
        logic [N-1:0] others;
        bit found;
        r = bif.req;
        if (!reset_n) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_last = 0; m_tevt = 1'b0;
        end else begin
            m_tevt = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!found && r[c]) begin
                        found = 1'b1; m_owner = c; m_last = c; m_cnt = 1;
                    end
                end
            end else begin
                others = r & ~(N'(1) << m_owner);
                if (!r[m_owner]) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1;
                end else if (TO_EN && m_cnt == MH && others != 0) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1; m_tevt = 1'b1;
                end else if (m_cnt < MH) begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_grant", 32'(bif.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_grant_id", 32'(bif.grant_id), 32'(m_last));
            chk("m_valid", 32'(bif.grant_valid), 32'(m_owner >= 0));
            chk("m_tevt", 32'(bif.timeout_evt), 32'(m_tevt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bif.req = '0;
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        bif.req = '0;
        cyc();
        chk_en = 1'b1;
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_valid", 32'(bif.grant_valid), 32'h0);
        reset_n = 1'b1;

        // Single requester: grant, dead cycle, re-grant.
        bif.req = 4'b0001; cyc();
        chk("single_grant", 32'(bif.grant), 32'h1);
        bif.req = 4'b0000; cyc();
        chk("single_drop", 32'(bif.grant), 32'h0);
        bif.req = 4'b0001; cyc();
        chk("single_regrant", 32'(bif.grant), 32'h1);

        // Reset while master 2 owns.
        bif.req = 4'b0000; cyc();
        bif.req = 4'b0100; cyc();
        chk("m2_owns", 32'(bif.grant), 32'h4);
        reset_n = 1'b0; cyc();
        chk("midrst_grant", 32'(bif.grant), 32'h0);
        chk("midrst_id", 32'(bif.grant_id), 32'h0);
        chk("midrst_valid", 32'(bif.grant_valid), 32'h0);
        reset_n = 1'b1; bif.req = 4'b0110; cyc();
        chk("post_rst_grant", 32'(bif.grant), 32'h2);

        // Round robin with all requesting.
        do_reset();
        bif.req = 4'hf; cyc();
        for (int k = 0; k < 5; k++) begin
            chk("rr_owner", 32'(bif.grant_id), 32'(k % 4));
            chk("rr_grant", 32'(bif.grant), 32'd1 << (k % 4));
            cyc(); cyc();
            bif.req = 4'hf & ~(4'(1) << (k % 4)); cyc();
            chk("rr_gap", 32'(bif.grant), 32'h0);
            bif.req = 4'hf; cyc();
        end

        // Wrap and skip.
        do_reset();
        bif.req = 4'b1000; cyc();
        chk("wrap_m3", 32'(bif.grant), 32'h8);
        bif.req = 4'b0101; cyc();
        chk("wrap_gap", 32'(bif.grant), 32'h0);
        cyc();
        chk("wrap_m0", 32'(bif.grant), 32'h1);
        bif.req = 4'b0100; cyc();
        cyc();
        chk("skip_m2", 32'(bif.grant), 32'h4);

        // Hold timeout with a competing requester.
        do_reset();
        bif.req = 4'b0001; cyc();
        bif.req = 4'b0101;
        cyc(); cyc(); cyc();
        chk("to_hold4", 32'(bif.grant), 32'h1);
        cyc();
        if (TO_EN) begin
            chk("to_release", 32'(bif.grant), 32'h0);
            chk("to_evt", 32'(bif.timeout_evt), 32'h1);
            cyc();
            chk("to_next", 32'(bif.grant), 32'h4);
            chk("to_evt_pulse", 32'(bif.timeout_evt), 32'h0);
        end else begin
            chk("noto_hold", 32'(bif.grant), 32'h1);
            chk("noto_evt", 32'(bif.timeout_evt), 32'h0);
            repeat (8) cyc();
            chk("noto_hold_long", 32'(bif.grant), 32'h1);
        end

        // Lone owner never times out.
        do_reset();
        bif.req = 4'b0001;
        repeat (10) cyc();
        chk("alone_grant", 32'(bif.grant), 32'h1);
        chk("alone_evt", 32'(bif.timeout_evt), 32'h0);

        // Randomized traffic, occasional reset.
        for (int t = 0; t < 3000; t++) begin
            logic [N-1:0] r;
            r = bif.req;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            end
            bif.req = r;
            reset_n = ($urandom_range(299) != 0);
            cyc();
        end
        reset_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin bus arbiter that shares the single system bus among up to eight masters. It replaces fixed two-master priority with fair rotation and a guaranteed one-cycle dead gap between owners. An optional hold-timeout forces rotation. It sits between the master request lines and the bus master-select mux, and drives one-hot grants plus an encoded owner index.

## Interface
- N_MASTER, 4: number of requesting masters, legal 2..8
- MAX_HOLD, 16: cycles an owner may keep the bus before forced release (timeout build only), legal 2..255
- clk  in  1  bus clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  N_MASTER  per-master bus request, level, held while bus needed
- grant  out  N_MASTER  one-hot grant, registered
- grant_id  out  $clog2(N_MASTER)  index of current owner, valid only when grant_valid=1
- grant_valid  out  1  OR of grant, registered
- timeout_evt  out  1  one-cycle pulse when a forced release occurs (held 0 when timeout compiled out)

## Operation
- Reset (reset_n=0 at an edge): state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout_evt=0, rotation pointer ptr=0, hold counter=0. Applies mid-ownership; grant drops at that edge.
- State IDLE: winner = first set bit of req scanning ptr, ptr+1, … wrapping modulo N_MASTER. If any req set: next edge grant[winner]=1, grant_id=winner, state=GRANT, counter=1. Else stay IDLE.
- State GRANT: owner keeps grant while req[owner]=1. Requests from other masters are ignored.
- Release: req[owner]=0 at an edge -> grant=0, grant_valid=0, ptr=owner+1 (wrap), state=IDLE. The IDLE cycle is the mandatory dead cycle; there is never back-to-back grant to different masters.
- Same master may be re-granted after its own release if it is the first requester from ptr. With no other requester, it wins after the dead cycle.
- Requests changing in the same cycle as release are handled by the next IDLE arbitration. No request is latched.
- grant is always one-hot or zero. grant_id holds the last owner while grant_valid=0.

## Timing
- Request to grant latency: 1 cycle from IDLE (req sampled at edge t, grant high after edge t).
- Release to next grant: owner req low sampled at edge t -> grant 0 after t -> new grant after t+1.
- Hold counter saturates at MAX_HOLD. It is reset to 1 on every new grant.

## Configuration
- HOLD_TIMEOUT_EN defined: in GRANT, when counter==MAX_HOLD and any other master requests, a forced release occurs at the next edge: grant=0, ptr=owner+1, timeout_evt=1 for one cycle, state=IDLE. The owner's request remains set but is ranked last by the rotated ptr. If no other master requests, the owner keeps the bus and the counter stays saturated.
- HOLD_TIMEOUT_EN undefined: there is no counter logic, timeout_evt is tied 0, and the owner holds the bus indefinitely.

## Structure
- Shared package bus_pkg: state enum (IDLE, GRANT), BUS_MAX_MASTERS=8, default MAX_HOLD constant.
- Sub-module rr_pick: combinational rotating priority picker. Inputs are req and ptr. Outputs are the one-hot winner, the winner index and an any flag. The arbiter instantiates it once.

## Test plan
- Reset during ownership: master 2 owns, reset_n=0 for one edge -> grant=0000, grant_id=0, grant_valid=0 next cycle. After release of reset with req=0110, master 1 is granted (ptr=0).
- Single requester: req=0001 from IDLE -> grant=0001 after 1 cycle. Drop req -> grant=0000 for 1 cycle. Reassert -> grant=0001 again.
- Round robin: req=1111 held, each owner drops its request for one cycle after 3 cycles of grant -> grant order 0,1,2,3,0, each separated by exactly one zero-grant cycle.
- Wrap and skip: owner 3 releases while req=0101 -> next grant=0001 (ptr wraps to 0). Owner 0 then releases with req=0100 -> grant=0100.
- Timeout (HOLD_TIMEOUT_EN, MAX_HOLD=4): master 0 holds req, master 2 requests -> grant 0001 for 4 cycles, then timeout_evt=1 with grant=0000, then grant=0100. With master 0 alone, grant stays 0001 and timeout_evt stays 0.
- Timeout compiled out: same stimulus as above -> grant stays 0001 indefinitely, timeout_evt=0.
